// File: rtl/mul_arb_pkg.sv
// -----------------------------------------------------------------------------
// mul_arb_pkg
//
// Shared definitions for the two-port multiplier arbiter:
//   - default operand width (DEFAULT_X) and default WAIT timeout (DEFAULT_TIMEOUT)
//   - FSM state encodings (plain localparam constants so older code that
//     compares against raw 3-bit codes keeps working)
//   - rrWinner(): the round-robin decision used by rr_pick2
// -----------------------------------------------------------------------------
package mul_arb_pkg;

    localparam int DEFAULT_X       = 8;
    localparam int DEFAULT_TIMEOUT = 32;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd3;
    localparam logic [STATE_W-1:0] ST_ABORT = 3'd4;

    // Round-robin choice between two requesters. lastServed is the port that
    // completed most recently; on a tie the other port wins. With a single
    // requester that requester wins regardless of lastServed.
    function automatic logic rrWinner(input logic req0,
                                      input logic req1,
                                      input logic lastServed);
        logic w;
        if (req0 && req1) begin
            w = ~lastServed;
        end else if (req1) begin
            w = 1'b1;
        end else begin
            w = 1'b0;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
//
// Purely combinational 2-way round-robin picker.
//
// Ports:
//   req0, req1  in   request levels of port 0 / port 1
//   ptr         in   port served last (tie goes to the other one)
//   winner      out  selected port index (meaningful only when valid=1)
//   valid       out  at least one port is requesting
// -----------------------------------------------------------------------------
module rr_pick2
    import mul_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic winner,
    output logic valid
);

    assign valid  = req0 | req1;
    assign winner = rrWinner(req0, req1, ptr);

endmodule

// File: rtl/mul_arbiter.sv
// -----------------------------------------------------------------------------
// mul_arbiter
//
// Round-robin controller sharing one sequential multiplier datapath between
// two requesters. It picks a winner, registers that port's operands onto
// dp_opa/dp_opb, pulses dp_load, waits for dp_ready, stores dp_mul into the
// winner's result register and pulses the winner's done for one cycle.
//
// Parameters:
//   x        operand width (product is 2*x bits)
//   TIMEOUT  maximum WAIT cycles before abort (only with MUL_ARB_TIMEOUT_EN)
//
// Optional feature macro:
//   MUL_ARB_TIMEOUT_EN  - adds a WAIT-cycle counter and an ABORT state that
//                         resets the datapath and pulses err for the winner.
//                         Undefined: WAIT lasts until dp_ready, err0/err1 = 0,
//                         dp_reset simply follows reset.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req0/req1               request levels, held until done or err
//   opa0,opb0 / opa1,opb1   operands per port
//   gnt0/gnt1               high from grant through DONE for that port
//   done0/done1             one-cycle completion pulse, res valid
//   res0/res1               product, held until that port's next completion
//   err0/err1               one-cycle timeout pulse
//   dp_load                 one-cycle load strobe to the datapath
//   dp_reset                datapath reset (reset, or abort)
//   dp_opa/dp_opb           operands of the granted port
//   dp_busy, dp_ready       datapath status
//   dp_mul                  datapath product
// -----------------------------------------------------------------------------
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int x       = DEFAULT_X,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
)
(
    input  logic           clk,
    input  logic           reset,
    input  logic           req0,
    input  logic           req1,
    input  logic [x-1:0]   opa0,
    input  logic [x-1:0]   opb0,
    input  logic [x-1:0]   opa1,
    input  logic [x-1:0]   opb1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           done0,
    output logic           done1,
    output logic [2*x-1:0] res0,
    output logic [2*x-1:0] res1,
    output logic           err0,
    output logic           err1,
    output logic           dp_load,
    output logic           dp_reset,
    output logic [x-1:0]   dp_opa,
    output logic [x-1:0]   dp_opb,
    input  logic           dp_busy,
    input  logic           dp_ready,
    input  logic [2*x-1:0] dp_mul
);

    logic [STATE_W-1:0] stateReg;
    logic [STATE_W-1:0] stateNext;
    logic               winnerReg;   // port owning the current operation
    logic               ptrReg;      // port served last
    logic [x-1:0]       opaReg;
    logic [x-1:0]       opbReg;
    logic [2*x-1:0]     resReg [2];

    logic pickWinner;
    logic pickValid;
    logic grantNow;
    logic captureNow;
    logic abortNow;

    logic [1:0] gntVec;
    logic [1:0] doneVec;
    logic [1:0] errVec;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .ptr    (ptrReg),
        .winner (pickWinner),
        .valid  (pickValid)
    );

    // A grant is only issued while the datapath is idle; dp_ready is only
    // meaningful in WAIT, so stray ready pulses elsewhere are ignored.
    assign grantNow   = (stateReg == ST_IDLE) && pickValid && !dp_busy;
    assign captureNow = (stateReg == ST_WAIT) && dp_ready;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int WAIT_CNT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_CNT_W-1:0] waitCntReg;

    // Counts completed WAIT cycles; cleared whenever the FSM is elsewhere so
    // every operation gets a full TIMEOUT budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCntReg <= '0;
        end else if (stateReg != ST_WAIT) begin
            waitCntReg <= '0;
        end else if (!dp_ready) begin
            waitCntReg <= waitCntReg + 1'b1;
        end
    end

    // The TIMEOUT-th WAIT cycle without ready moves to ABORT.
    assign abortNow = (stateReg == ST_WAIT) && !dp_ready &&
                      (waitCntReg == WAIT_CNT_W'(TIMEOUT - 1));

    assign dp_reset = reset | (stateReg == ST_ABORT);
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT == 0);
    assign abortNow      = 1'b0;
    assign dp_reset      = reset;
`endif

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_IDLE: begin
                if (grantNow) begin
                    stateNext = ST_LOAD;
                end
            end
            ST_LOAD: begin
                stateNext = ST_WAIT;
            end
            ST_WAIT: begin
                if (captureNow) begin
                    stateNext = ST_DONE;
                end else if (abortNow) begin
                    stateNext = ST_ABORT;
                end
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
            end
`ifdef MUL_ARB_TIMEOUT_EN
            ST_ABORT: begin
                stateNext = ST_IDLE;
            end
`endif
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // State, winner, operand and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg  <= ST_IDLE;
            winnerReg <= 1'b0;
            ptrReg    <= 1'b1;        // port 0 wins the first tie
            opaReg    <= '0;
            opbReg    <= '0;
        end else begin
            stateReg <= stateNext;
            if (grantNow) begin
                winnerReg <= pickWinner;
                opaReg    <= pickWinner ? opa1 : opa0;
                opbReg    <= pickWinner ? opb1 : opb0;
            end
            // Pointer moves only on a successful completion, never on abort.
            if (captureNow) begin
                ptrReg <= winnerReg;
            end
        end
    end

    // Per-port result registers and status decode
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_ff @(posedge clk) begin
                if (reset) begin
                    resReg[gi] <= '0;
                end else if (captureNow && (winnerReg == 1'(gi))) begin
                    resReg[gi] <= dp_mul;
                end
            end

            // Grant covers LOAD, WAIT, DONE (and ABORT while it lasts).
            assign gntVec[gi]  = (stateReg != ST_IDLE) && (winnerReg == 1'(gi));
            assign doneVec[gi] = (stateReg == ST_DONE) && (winnerReg == 1'(gi));
`ifdef MUL_ARB_TIMEOUT_EN
            assign errVec[gi]  = (stateReg == ST_ABORT) && (winnerReg == 1'(gi));
`else
            assign errVec[gi]  = 1'b0;
`endif
        end
    endgenerate

    assign gnt0    = gntVec[0];
    assign gnt1    = gntVec[1];
    assign done0   = doneVec[0];
    assign done1   = doneVec[1];
    assign err0    = errVec[0];
    assign err1    = errVec[1];
    assign res0    = resReg[0];
    assign res1    = resReg[1];
    assign dp_load = (stateReg == ST_LOAD);
    assign dp_opa  = opaReg;
    assign dp_opb  = opbReg;

endmodule

// File: tb/tb_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_arbiter
//
// Directed bench for mul_arbiter with a small behavioural multiplier model.
// Expected products are pushed to a scoreboard queue when requests are
// raised and popped when a done pulse appears.
// -----------------------------------------------------------------------------
module tb_mul_arbiter;

    localparam int X   = 8;
    localparam int TO  = 32;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           req0, req1;
    logic [X-1:0]   opa0, opb0, opa1, opb1;
    logic           gnt0, gnt1, done0, done1, err0, err1;
    logic [2*X-1:0] res0, res1;
    logic           dp_load, dp_reset;
    logic [X-1:0]   dp_opa, dp_opb;
    logic           dp_busy, dp_ready;
    logic [2*X-1:0] dp_mul;

    // datapath model state
    logic           busyM;
    logic [3:0]     cntM;
    logic [2*X-1:0] prodM;
    logic           forceBusy;
    logic           suppressReady;

    typedef struct {
        bit             port;
        logic [2*X-1:0] prod;
    } sbEntry_t;

    sbEntry_t sbQ[$];

    int testCnt = 0;
    int failCnt = 0;
    bit watchGnt1 = 0;
    bit sawGnt1 = 0;

    always #5 clk = ~clk;

    mul_arbiter #(.x(X), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .opa0     (opa0),
        .opb0     (opb0),
        .opa1     (opa1),
        .opb1     (opb1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .res0     (res0),
        .res1     (res1),
        .err0     (err0),
        .err1     (err1),
        .dp_load  (dp_load),
        .dp_reset (dp_reset),
        .dp_opa   (dp_opa),
        .dp_opb   (dp_opb),
        .dp_busy  (dp_busy),
        .dp_ready (dp_ready),
        .dp_mul   (dp_mul)
    );

    // Behavioural sequential multiplier: LAT cycles busy, then one ready cycle.
    always @(posedge clk) begin
        if (dp_reset) begin
            busyM    <= 1'b0;
            cntM     <= '0;
            dp_ready <= 1'b0;
            prodM    <= '0;
            dp_mul   <= '0;
        end else if (dp_load) begin
            busyM    <= 1'b1;
            cntM     <= 4'(LAT);
            prodM    <= (2*X)'(dp_opa) * (2*X)'(dp_opb);
            dp_ready <= 1'b0;
        end else if (busyM) begin
            if (cntM == 4'd1) begin
                busyM    <= 1'b0;
                dp_ready <= !suppressReady;
                dp_mul   <= prodM;
            end else begin
                cntM <= cntM - 4'd1;
            end
        end else begin
            dp_ready <= 1'b0;
        end
    end

    assign dp_busy = busyM | forceBusy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input bit port, input int a, input int b);
        sbEntry_t e;
        e.port = port;
        e.prod = (2*X)'(a * b);
        sbQ.push_back(e);
    endtask

    // sel: 0 done0, 1 done1, 2 gnt0, 3 gnt1
    task automatic waitSig(input int sel, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = done0;
                1: hit = done1;
                2: hit = gnt0;
                default: hit = gnt1;
            endcase
        end
        check({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (watchGnt1 && (gnt1 || done1)) sawGnt1 = 1'b1;
            if (done0 || done1) begin
                check("done_exclusive", 32'(done0 & done1), 32'd0);
                if (sbQ.size() == 0) begin
                    check("done_expected", 32'd1, 32'd0);
                end else begin
                    sbEntry_t e;
                    e = sbQ.pop_front();
                    check("done_port", 32'(done1), 32'(e.port));
                    check("result", 32'(done1 ? res1 : res0), 32'(e.prod));
                    $display("[TB] done port %0d result %0d", done1, done1 ? res1 : res0);
                end
            end
        end
    end

    initial begin
        bit anyBad;
        reset = 1'b1;
        req0 = 0; req1 = 0;
        opa0 = 0; opb0 = 0; opa1 = 0; opb1 = 0;
        forceBusy = 0; suppressReady = 0;
        repeat (3) @(negedge clk);

        // ---- reset state
        check("rst_dp_reset", 32'(dp_reset), 32'd1);
        check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("rst_done_err", 32'({done0, done1, err0, err1}), 32'd0);
        check("rst_dp_load", 32'(dp_load), 32'd0);
        check("rst_opnds", 32'({dp_opa, dp_opb}), 32'd0);
        check("rst_res", 32'({res0, res1}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_dp_reset", 32'(dp_reset), 32'd0);

        // ---- single request on port 0: 12 x 10
        watchGnt1 = 1;
        opa0 = 12; opb0 = 10; req0 = 1;
        push(0, 12, 10);
        @(negedge clk);
        check("t1_gnt0", 32'(gnt0), 32'd1);
        check("t1_load", 32'(dp_load), 32'd1);
        check("t1_opa", 32'(dp_opa), 32'd12);
        check("t1_opb", 32'(dp_opb), 32'd10);
        @(negedge clk);
        check("t1_load_once", 32'(dp_load), 32'd0);
        waitSig(0, "t1_done0");
        check("t1_gnt_in_done", 32'(gnt0), 32'd1);
        req0 = 0;
        @(negedge clk);
        check("t1_gnt_clear", 32'(gnt0), 32'd0);
        check("t1_done_pulse", 32'(done0), 32'd0);
        check("t1_res0_hold", 32'(res0), 32'd120);
        watchGnt1 = 0;
        check("t1_no_port1", 32'(sawGnt1), 32'd0);

        // ---- ties after reset: port 0 first, then port 1, next tie port 0
        reset = 1; @(negedge clk); reset = 0;
        opa0 = 7; opb0 = 9; opa1 = 255; opb1 = 255;
        req0 = 1; req1 = 1;
        push(0, 7, 9); push(1, 255, 255);
        waitSig(0, "t2_done0");
        req0 = 0;
        waitSig(1, "t2_done1");
        req1 = 0;
        check("t2_res1", 32'(res1), 32'd65025);
        opa0 = 3; opb0 = 5; opa1 = 4; opb1 = 6;
        req0 = 1; req1 = 1;
        push(0, 3, 5); push(1, 4, 6);
        waitSig(0, "t2b_done0");
        req0 = 0;
        waitSig(1, "t2b_done1");
        req1 = 0;

        // ---- req1 held, req0 pulsing: grants 1,0,1,0
        opa0 = 5; opb0 = 5; opa1 = 2; opb1 = 3;
        req1 = 1; push(1, 2, 3);
        waitSig(3, "t3_gnt1_a");
        req0 = 1; push(0, 5, 5);
        waitSig(1, "t3_done1_a");
        push(1, 2, 3);              // req1 stays high: new request
        waitSig(0, "t3_done0_a");
        req0 = 0;
        waitSig(3, "t3_gnt1_b");
        req0 = 1; push(0, 5, 5);
        waitSig(1, "t3_done1_b");
        req1 = 0;
        waitSig(0, "t3_done0_b");
        req0 = 0;
        @(negedge clk);

        // ---- dp_busy holds off the grant
        forceBusy = 1;
        opa0 = 4; opb0 = 4; req0 = 1;
        anyBad = 0;
        repeat (5) begin
            @(negedge clk);
            if (dp_load || gnt0) anyBad = 1;
        end
        check("t4_no_load_busy", 32'(anyBad), 32'd0);
        forceBusy = 0;
        push(0, 4, 4);
        @(negedge clk);
        check("t4_load_after", 32'(dp_load), 32'd1);
        waitSig(0, "t4_done0");
        req0 = 0;

        // ---- reset during WAIT
        opa0 = 9; opb0 = 9; req0 = 1;
        waitSig(2, "t5_gnt0");
        @(negedge clk);             // now in WAIT
        reset = 1;
        @(negedge clk);
        reset = 0; req0 = 0;
        check("t5_gnt0", 32'(gnt0), 32'd0);
        check("t5_res0", 32'(res0), 32'd0);
        anyBad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done0 || done1 || gnt0) anyBad = 1;
        end
        check("t5_quiet", 32'(anyBad), 32'd0);

        // ---- datapath never ready
        suppressReady = 1;
        opa0 = 6; opb0 = 7; req0 = 1;
        @(negedge clk);
        check("t6_load", 32'(dp_load), 32'd1);
`ifdef MUL_ARB_TIMEOUT_EN
        anyBad = 0;
        repeat (TO) begin
            @(negedge clk);
            if (err0 || err1 || dp_reset || !gnt0) anyBad = 1;
        end
        check("t6_wait_span", 32'(anyBad), 32'd0);
        @(negedge clk);
        check("t6_err0", 32'(err0), 32'd1);
        check("t6_dp_reset", 32'(dp_reset), 32'd1);
        check("t6_res0", 32'(res0), 32'd0);
        req0 = 0;
        @(negedge clk);
        check("t6_err_pulse", 32'({err0, dp_reset}), 32'd0);
        check("t6_gnt_clear", 32'(gnt0), 32'd0);
`else
        anyBad = 0;
        repeat (TO + 8) begin
            @(negedge clk);
            if (err0 || err1 || dp_reset || !gnt0 || done0) anyBad = 1;
        end
        check("t6_stuck_wait", 32'(anyBad), 32'd0);
        reset = 1; req0 = 0;
        @(negedge clk);
        reset = 0;
`endif
        suppressReady = 0;
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sbQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Two-port round-robin controller sharing one sequential multiplier datapath (x-bit operands, 2x-bit product) between two requesters. Arbitrates, drives the datapath load/operands, waits for its ready, and returns the registered product to the winner with a one-cycle done pulse. Sits between the multiplier datapath and its client blocks, replacing direct bench drive of load/OpA/OpB.

## Interface
- x, 8: operand width; product is 2x bits
- TIMEOUT, 32: max WAIT cycles before abort; used only with MUL_ARB_TIMEOUT_EN
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  request level, held until matching done or err
- opa0, opb0 / opa1, opb1  in  x  operands, stable while req held
- gnt0 / gnt1  out  1  high from grant through DONE for that port
- done0 / done1  out  1  one-cycle pulse; res valid
- res0 / res1  out  2x  product, held until that port's next completion
- err0 / err1  out  1  one-cycle timeout pulse (0 when macro absent)
- dp_load  out  1  one-cycle load pulse to datapath
- dp_reset  out  1  datapath reset = reset OR abort
- dp_opa, dp_opb  out  x  operands of granted port, registered at grant
- dp_busy  in  1  datapath computing
- dp_ready  in  1  datapath product valid
- dp_mul  in  2x  datapath product

## Operation
- FSM: IDLE, LOAD, WAIT, DONE (plus ABORT with macro).
- IDLE: if (req0|req1) and !dp_busy, pick winner, latch its operands into dp_opa/dp_opb, set gnt, -> LOAD. Otherwise stay.
- Round-robin: both requesting -> port not served last wins; one requesting -> it wins. Pointer updates on entering DONE (not on abort). After reset pointer = 1, so port 0 wins first tie.
- LOAD: dp_load=1 for exactly one cycle -> WAIT.
- WAIT: on dp_ready=1 capture dp_mul into winner's res -> DONE. dp_ready outside WAIT ignored.
- DONE: winner's done=1 one cycle, gnt cleared on exit -> IDLE.
- Requester must deassert req the cycle after done; a still-high req is treated as new request.
- req dropped mid-operation: operation completes, done still pulses, result stored.
- Reset values: state IDLE, all gnt/done/err/dp_load 0, dp_opa/dp_opb/res0/res1 0, pointer 1; dp_reset=1 during reset.
- Reset mid-operation: immediate return to IDLE, no done/err pulse, res keeps reset value 0.

## Timing
- Request seen in IDLE at cycle T (dp_busy=0): gnt at T+1, dp_load at T+1, WAIT from T+2.
- dp_ready sampled high at cycle R: res updated and done pulsed at R+1; IDLE at R+2.
- Back-to-back: new grant earliest at R+2 -> dp_load at R+3.
- Total latency req->done = datapath latency + 3 cycles.

## Configuration
- MUL_ARB_TIMEOUT_EN defined: counter counts WAIT cycles; reaching TIMEOUT without dp_ready -> ABORT: dp_reset=1 one cycle, err pulse for winner, res unchanged, pointer unchanged, -> IDLE next cycle.
- Undefined: no counter, no ABORT state, WAIT indefinite, err0/err1 tied 0, dp_reset=reset.

## Structure
- Package mul_arb_pkg: state encoding localparams, default x, default TIMEOUT.
- Sub-module rr_pick2: combinational 2-way round-robin picker (req0, req1, pointer -> winner, valid).
- FSM, operand/result registers, timeout counter in mul_arbiter.

## Test plan
- Reset, then req0 with opa0=12, opb0=10 -> dp_load at T+1, dp_opa=12, after dp_ready done0 pulse, res0=120, gnt1/done1 never set.
- req0 and req1 same cycle (7x9, 255x255) -> port 0 served first (res0=63), then port 1 (res1=65025); next tie goes to port 0.
- req1 held continuously with req0 pulsing -> grants alternate 1,0,1,0; no starvation.
- dp_busy=1 while req0 high -> no dp_load until dp_busy=0.
- reset asserted in WAIT -> next cycle IDLE, no done pulse, gnt0=0, res0=0.
- With MUL_ARB_TIMEOUT_EN, TIMEOUT=32, dp_ready never asserted -> err0 pulse after 32 WAIT cycles, dp_reset one cycle, res0 unchanged; without macro, FSM stays in WAIT.
